// File: rtl/fsm_saw_receiver.sv
// Stop-and-Wait ARQ receiver: validates incoming frames, delivers new ones in order,
// and returns ACK(Rn). Corrupted frames are dropped silently; duplicates are re-ACKed.
module fsm_saw_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEQ_W  = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic [SEQ_W-1:0]  frame_seq,
  input  logic              frame_corrupt,
  input  logic [DATA_W-1:0] frame_data,
  output logic              deliver_valid,
  input  logic              deliver_ready,
  output logic [DATA_W-1:0] deliver_data,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic [SEQ_W-1:0]  ack_seq,
  output logic [SEQ_W-1:0]  rn,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  dup_cnt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_READY   = 3'd0,
    S_CHECK   = 3'd1,
    S_DELIVER = 3'd2,
    S_ACK     = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              st;
  logic [SEQ_W-1:0]    seq_q;
  logic                corrupt_q;
  logic [DATA_W-1:0]   data_q;
  logic [SEQ_W-1:0]    rn_inc;

  // Rn advances modulo 2^SEQ_W; the truncation provides the wrap.
  assign rn_inc = SEQ_W'(rn + 1'b1);
  assign state  = st;

  // Single-frame-in-flight FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= S_READY;
      frame_ready   <= 1'b1;
      deliver_valid <= 1'b0;
      deliver_data  <= '0;
      ack_valid     <= 1'b0;
      ack_seq       <= '0;
      rn            <= '0;
      err_cnt       <= '0;
      dup_cnt       <= '0;
      seq_q         <= '0;
      corrupt_q     <= 1'b0;
      data_q        <= '0;
    end else begin
      case (st)
        S_READY: begin
          if (frame_valid && frame_ready) begin
            seq_q       <= frame_seq;
            corrupt_q   <= frame_corrupt;
            data_q      <= frame_data;
            frame_ready <= 1'b0;
            st          <= S_CHECK;
          end
        end

        // Corruption takes priority: a bad checksum makes the sequence field meaningless.
        S_CHECK: begin
          if (corrupt_q) begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
            st <= S_DISCARD;
          end else if (seq_q == rn) begin
            deliver_valid <= 1'b1;
            deliver_data  <= data_q;
            st            <= S_DELIVER;
          end else begin
            if (dup_cnt != CNT_MAX) dup_cnt <= dup_cnt + CNT_W'(1);
            ack_seq   <= rn;
            ack_valid <= 1'b1;
            st        <= S_ACK;
          end
        end

        S_DELIVER: begin
          if (deliver_ready) begin
            deliver_valid <= 1'b0;
            rn            <= rn_inc;
            ack_seq       <= rn_inc;
            ack_valid     <= 1'b1;
            st            <= S_ACK;
          end
        end

        S_ACK: begin
          if (ack_ready) begin
            ack_valid   <= 1'b0;
            frame_ready <= 1'b1;
            st          <= S_READY;
          end
        end

        // No ACK for a corrupted frame: the transmitter's timeout drives the resend.
        S_DISCARD: begin
          frame_ready <= 1'b1;
          st          <= S_READY;
        end

        default: begin
          deliver_valid <= 1'b0;
          ack_valid     <= 1'b0;
          frame_ready   <= 1'b1;
          st            <= S_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_saw_receiver.sv
// Bench for the SAW receiver: directed scenarios plus randomized frames checked
// against a transaction-level ARQ receiver model.
module tb_fsm_saw_receiver;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEQ_W  = 1;
  localparam int unsigned CNT_W  = 2;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int SMOD = 1 << SEQ_W;

  localparam logic [2:0] ST_READY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_DELIVER = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_valid;
  logic              frame_ready;
  logic [SEQ_W-1:0]  frame_seq;
  logic              frame_corrupt;
  logic [DATA_W-1:0] frame_data;
  logic              deliver_valid;
  logic              deliver_ready;
  logic [DATA_W-1:0] deliver_data;
  logic              ack_valid;
  logic              ack_ready;
  logic [SEQ_W-1:0]  ack_seq;
  logic [SEQ_W-1:0]  rn;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  dup_cnt;
  logic [2:0]        state;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model of the receiver's visible bookkeeping
  int m_rn  = 0;
  int m_err = 0;
  int m_dup = 0;

  always #5 clk = ~clk;

  fsm_saw_receiver #(.DATA_W(DATA_W), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_seq(frame_seq),
    .frame_corrupt(frame_corrupt), .frame_data(frame_data),
    .deliver_valid(deliver_valid), .deliver_ready(deliver_ready), .deliver_data(deliver_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_seq(ack_seq),
    .rn(rn), .err_cnt(err_cnt), .dup_cnt(dup_cnt), .state(state)
  );

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic offer(input logic [SEQ_W-1:0] s, input logic c, input logic [DATA_W-1:0] d);
    int k = 0;
    frame_valid = 1'b1; frame_seq = s; frame_corrupt = c; frame_data = d;
    while (frame_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_tests++;
    if (frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_timeout: frame_ready=%b after %0d cycles, required 1", frame_ready, k);
    end
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_valid = 1'b0; frame_seq = '0; frame_corrupt = 1'b0; frame_data = '0;
    deliver_ready = 1'b1; ack_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({state, frame_ready, deliver_valid, ack_valid} !== {ST_READY, 3'b100}) begin
      n_fail++; $display("FAIL reset_ctrl: state=%0d fr=%b dv=%b av=%b, required 0 1 0 0",
                         state, frame_ready, deliver_valid, ack_valid);
    end
    n_tests++;
    if (rn !== '0 || ack_seq !== '0 || deliver_data !== '0 || err_cnt !== '0 || dup_cnt !== '0) begin
      n_fail++; $display("FAIL reset_regs: rn=%0d ack_seq=%0d data=%h err=%0d dup=%0d, required all 0",
                         rn, ack_seq, deliver_data, err_cnt, dup_cnt);
    end
    m_rn = 0; m_err = 0; m_dup = 0;
  endtask

  task automatic test_new_frame();
    deliver_ready = 1'b1; ack_ready = 1'b1;
    offer(1'b0, 1'b0, 8'hA5);
    n_tests++;
    if (state !== ST_CHECK || deliver_valid !== 1'b0) begin
      n_fail++; $display("FAIL new_t1: state=%0d dv=%b, required 1 0", state, deliver_valid);
    end
    @(negedge clk);
    n_tests++;
    if (deliver_valid !== 1'b1 || deliver_data !== 8'hA5) begin
      n_fail++; $display("FAIL new_t2_deliver: dv=%b data=%h, required 1 a5", deliver_valid, deliver_data);
    end
    @(negedge clk);
    n_tests++;
    if (ack_valid !== 1'b1 || ack_seq !== 1'b1 || rn !== 1'b1 || deliver_valid !== 1'b0) begin
      n_fail++; $display("FAIL new_t3_ack: av=%b ack_seq=%0d rn=%0d dv=%b, required 1 1 1 0",
                         ack_valid, ack_seq, rn, deliver_valid);
    end
    @(negedge clk);
    n_tests++;
    if (state !== ST_READY || frame_ready !== 1'b1 || ack_valid !== 1'b0) begin
      n_fail++; $display("FAIL new_t4_ready: state=%0d fr=%b av=%b, required 0 1 0", state, frame_ready, ack_valid);
    end
    m_rn = 1;
  endtask

  task automatic test_corrupt();
    offer(1'b1, 1'b1, 8'h3C);
    @(negedge clk);
    n_tests++;
    if (state !== ST_DISCARD || deliver_valid !== 1'b0 || ack_valid !== 1'b0 || err_cnt !== 2'd1) begin
      n_fail++; $display("FAIL corrupt_discard: state=%0d dv=%b av=%b err=%0d, required 4 0 0 1",
                         state, deliver_valid, ack_valid, err_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (state !== ST_READY || frame_ready !== 1'b1 || rn !== 1'b1 || ack_valid !== 1'b0) begin
      n_fail++; $display("FAIL corrupt_ready: state=%0d fr=%b rn=%0d av=%b, required 0 1 1 0",
                         state, frame_ready, rn, ack_valid);
    end
    m_err = 1;
  endtask

  task automatic test_duplicate();
    offer(1'b0, 1'b0, 8'h77);
    @(negedge clk);
    n_tests++;
    if (state !== ST_ACK || ack_valid !== 1'b1 || ack_seq !== 1'b1 || dup_cnt !== 2'd1 || deliver_valid !== 1'b0) begin
      n_fail++; $display("FAIL dup_ack: state=%0d av=%b ack_seq=%0d dup=%0d dv=%b, required 3 1 1 1 0",
                         state, ack_valid, ack_seq, dup_cnt, deliver_valid);
    end
    @(negedge clk);
    n_tests++;
    if (state !== ST_READY || rn !== 1'b1) begin
      n_fail++; $display("FAIL dup_ready: state=%0d rn=%0d, required 0 1", state, rn);
    end
    m_dup = 1;
  endtask

  task automatic test_backpressure();
    deliver_ready = 1'b0; ack_ready = 1'b0;
    offer(1'b1, 1'b0, 8'hC3);
    frame_valid = 1'b1; frame_seq = 1'b0; frame_data = 8'h11; frame_corrupt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (deliver_valid !== 1'b1 || deliver_data !== 8'hC3 || frame_ready !== 1'b0 || state !== ST_DELIVER) begin
        n_fail++; $display("FAIL bp_deliver_hold[%0d]: dv=%b data=%h fr=%b state=%0d, required 1 c3 0 2",
                           i, deliver_valid, deliver_data, frame_ready, state);
      end
      @(negedge clk);
    end
    deliver_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ack_valid !== 1'b1 || ack_seq !== 1'b0 || frame_ready !== 1'b0 || deliver_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_ack_hold[%0d]: av=%b ack_seq=%0d fr=%b dv=%b, required 1 0 0 0",
                           i, ack_valid, ack_seq, frame_ready, deliver_valid);
      end
      @(negedge clk);
    end
    frame_valid = 1'b0; ack_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (state !== ST_READY || rn !== 1'b0 || dup_cnt !== 2'd1) begin
      n_fail++; $display("FAIL bp_release: state=%0d rn=%0d dup=%0d, required 0 0 1", state, rn, dup_cnt);
    end
    m_rn = 0;
  endtask

  // Runs one frame through to completion with random readys and checks it against the model.
  task automatic run_frame(input logic [SEQ_W-1:0] s, input logic c, input logic [DATA_W-1:0] d,
                           input bit rand_ready, input string tag);
    bit exp_del, exp_ack;
    int got_del = 0, got_ack = 0, cyc = 0;
    logic [DATA_W-1:0] got_data = '0;
    logic [SEQ_W-1:0]  got_seq = '0;
    exp_del = 1'b0; exp_ack = 1'b0;
    if (c) begin
      m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
    end else if (int'(s) == m_rn) begin
      exp_del = 1'b1; exp_ack = 1'b1; m_rn = (m_rn + 1) % SMOD;
    end else begin
      exp_ack = 1'b1; m_dup = (m_dup < CMAX) ? m_dup + 1 : CMAX;
    end
    offer(s, c, d);
    while (frame_ready !== 1'b1 && cyc < 64) begin
      if (rand_ready) begin
        deliver_ready = 1'($urandom_range(0, 1));
        ack_ready     = 1'($urandom_range(0, 1));
      end
      if (deliver_valid && deliver_ready) begin got_del++; got_data = deliver_data; end
      if (ack_valid && ack_ready) begin got_ack++; got_seq = ack_seq; end
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (frame_ready !== 1'b1 || got_del != int'(exp_del) || (exp_del && got_data !== d)) begin
      n_fail++; $display("FAIL %s_deliver: fr=%b delivered=%0d data=%h, required 1 %0d %h",
                         tag, frame_ready, got_del, got_data, exp_del, d);
    end
    n_tests++;
    if (got_ack != int'(exp_ack) || (exp_ack && int'(got_seq) != m_rn)) begin
      n_fail++; $display("FAIL %s_ack: acks=%0d ack_seq=%0d, required %0d %0d", tag, got_ack, got_seq, exp_ack, m_rn);
    end
    n_tests++;
    if (int'(rn) != m_rn || int'(err_cnt) != m_err || int'(dup_cnt) != m_dup) begin
      n_fail++; $display("FAIL %s_stats: rn=%0d err=%0d dup=%0d, required %0d %0d %0d",
                         tag, rn, err_cnt, dup_cnt, m_rn, m_err, m_dup);
    end
  endtask

  task automatic test_wrap_saturation();
    logic [SEQ_W-1:0] sq;
    deliver_ready = 1'b1; ack_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sq = SEQ_W'(i % 2);
      run_frame(sq, 1'b0, DATA_W'(8'h40 + i), 1'b0, "wrap");
    end
    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b1, 8'hEE, 1'b0, "sat");
    n_tests++;
    if (err_cnt !== 2'd3) begin
      n_fail++; $display("FAIL sat_err_cnt: err=%0d, required 3", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    deliver_ready = 1'b0;
    offer(SEQ_W'(m_rn), 1'b0, 8'h5A);
    while (state !== ST_DELIVER && k < 10) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (state !== ST_READY || deliver_valid !== 1'b0 || ack_valid !== 1'b0 || rn !== '0 ||
        err_cnt !== '0 || dup_cnt !== '0 || frame_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: state=%0d dv=%b av=%b rn=%0d err=%0d dup=%0d fr=%b, required 0 0 0 0 0 0 1",
                         state, deliver_valid, ack_valid, rn, err_cnt, dup_cnt, frame_ready);
    end
    rst = 1'b0; deliver_ready = 1'b1;
    m_rn = 0; m_err = 0; m_dup = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [SEQ_W-1:0]  s;
    logic              c;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 40; i++) begin
      s = SEQ_W'($urandom_range(0, SMOD - 1));
      c = ($urandom_range(0, 3) == 0);
      d = DATA_W'($urandom);
      deliver_ready = 1'($urandom_range(0, 1));
      ack_ready     = 1'($urandom_range(0, 1));
      run_frame(s, c, d, 1'b1, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_new_frame();
    test_corrupt();
    test_duplicate();
    test_backpressure();
    test_wrap_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
